// File: rtl/cmp_window_stat.sv
// Windowed max/min tracker for the compare stage output: collects WIN samples, then holds
// the result until downstream accepts it. Minimum tracking is built only with CMP_STAT_MIN_EN.
module cmp_window_stat #(
    parameter int WIH = 3,
    parameter int WIN = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [WIH-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [WIH-1:0] max_val,
`ifdef CMP_STAT_MIN_EN
    output logic [WIH-1:0] min_val,
`endif
    output logic [7:0]     sample_cnt
);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [7:0] WIN_C = 8'(WIN);

    state_t         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [WIH-1:0] max_q, max_d;
`ifdef CMP_STAT_MIN_EN
    logic [WIH-1:0] min_q, min_d;
`endif

    logic       accept;
    logic [7:0] cnt_inc;

    // Readiness depends only on state, so a result handshake always costs one bubble cycle.
    assign in_ready   = (state_q == ACC);
    assign out_valid  = (state_q == HOLD);
    assign accept     = in_valid && in_ready;
    assign cnt_inc    = cnt_q + 8'd1;

    assign max_val    = max_q;
    assign sample_cnt = cnt_q;
`ifdef CMP_STAT_MIN_EN
    assign min_val    = min_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
`ifdef CMP_STAT_MIN_EN
        min_d   = min_q;
`endif
        if (clr) begin
            state_d = ACC;
            cnt_d   = 8'd0;
            max_d   = '0;
`ifdef CMP_STAT_MIN_EN
            min_d   = '0;
`endif
        end else begin
            case (state_q)
                ACC: begin
                    if (accept) begin
                        cnt_d = cnt_inc;
                        // The first sample seeds the extremes; stale values from the last window are ignored.
                        if (cnt_q == 8'd0) begin
                            max_d = in_data;
`ifdef CMP_STAT_MIN_EN
                            min_d = in_data;
`endif
                        end else begin
                            if (in_data > max_q) max_d = in_data;
`ifdef CMP_STAT_MIN_EN
                            if (in_data < min_q) min_d = in_data;
`endif
                        end
                        if (cnt_inc == WIN_C) state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = ACC;
                        cnt_d   = 8'd0;
                    end
                end
                default: state_d = ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            cnt_q   <= 8'd0;
            max_q   <= '0;
`ifdef CMP_STAT_MIN_EN
            min_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
`ifdef CMP_STAT_MIN_EN
            min_q   <= min_d;
`endif
        end
    end

endmodule

// File: tb/tb_cmp_window_stat.sv
// Bench for cmp_window_stat: directed vector table, async-reset sequence, then random
// traffic against a queue-based window model. Min checks follow CMP_STAT_MIN_EN.
module tb_cmp_window_stat;

    localparam int WIH = 3;
    localparam int WIN = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           clr;
    logic           in_valid;
    logic           in_ready;
    logic [WIH-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [WIH-1:0] max_val;
    logic [7:0]     sample_cnt;
`ifdef CMP_STAT_MIN_EN
    logic [WIH-1:0] min_val;
`endif

    cmp_window_stat #(.WIH(WIH), .WIN(WIN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .max_val    (max_val),
`ifdef CMP_STAT_MIN_EN
        .min_val    (min_val),
`endif
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int ov, input int cnt, input int mx, input int mn);
        check({tag, " out_valid"}, int'(out_valid), ov);
        check({tag, " in_ready"}, int'(in_ready), (ov != 0) ? 0 : 1);
        check({tag, " sample_cnt"}, int'(sample_cnt), cnt);
        check({tag, " max_val"}, int'(max_val), mx);
`ifdef CMP_STAT_MIN_EN
        check({tag, " min_val"}, int'(min_val), mn);
`else
        if (mn < 0) check({tag, " min_val"}, 0, 0);
`endif
    endtask

    // Reference model: the window is a list of accepted samples; extremes are taken over it.
    int m_win[$];
    bit m_hold;
    int m_max, m_min;

    task automatic model_reset();
        m_win.delete();
        m_hold = 1'b0;
        m_max  = 0;
        m_min  = 0;
    endtask

    task automatic model_step(input bit c, input bit iv, input int d, input bit ordy);
        if (c) begin
            model_reset();
        end else if (!m_hold) begin
            if (iv) begin
                m_win.push_back(d);
                m_max = m_win[0];
                m_min = m_win[0];
                foreach (m_win[i]) begin
                    if (m_win[i] > m_max) m_max = m_win[i];
                    if (m_win[i] < m_min) m_min = m_win[i];
                end
                if (m_win.size() == WIN) m_hold = 1'b1;
            end
        end else if (ordy) begin
            m_hold = 1'b0;
            m_win.delete();
        end
    endtask

    typedef struct {
        bit clr;
        bit iv;
        int d;
        bit ordy;
        int ov;
        int cnt;
        int mx;
        int mn;
    } vec_t;

    vec_t vt[$];

    task automatic add(input bit c, input bit iv, input int d, input bit ordy,
                       input int ov, input int cnt, input int mx, input int mn);
        vec_t v;
        v.clr = c; v.iv = iv; v.d = d; v.ordy = ordy;
        v.ov = ov; v.cnt = cnt; v.mx = mx; v.mn = mn;
        vt.push_back(v);
    endtask

    task automatic drive(input bit c, input bit iv, input int d, input bit ordy);
        clr       = c;
        in_valid  = iv;
        in_data   = WIH'(d);
        out_ready = ordy;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0);

        // basic window 2,5,1,3
        add(0, 1, 2, 0, 0, 1, 2, 2);
        add(0, 1, 5, 0, 0, 2, 5, 2);
        add(0, 1, 1, 0, 0, 3, 5, 1);
        add(0, 1, 3, 0, 1, 4, 5, 1);
        // backpressure with a competing sample of 7
        for (int i = 0; i < 5; i++) add(0, 1, 7, 0, 1, 4, 5, 1);
        add(0, 1, 7, 1, 0, 0, 5, 1);
        // clear mid-window, sample on the clear cycle discarded
        add(0, 1, 6, 0, 0, 1, 6, 6);
        add(0, 1, 6, 0, 0, 2, 6, 6);
        add(1, 1, 7, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 2, 0, 0);
        add(0, 1, 0, 0, 0, 3, 0, 0);
        add(0, 1, 4, 0, 1, 4, 4, 0);
        add(0, 0, 0, 1, 0, 0, 4, 0);
        // equal samples separated by idle cycles
        add(0, 1, 3, 0, 0, 1, 3, 3);
        add(0, 0, 5, 0, 0, 1, 3, 3);
        add(0, 1, 3, 0, 0, 2, 3, 3);
        add(0, 0, 6, 0, 0, 2, 3, 3);
        add(0, 1, 3, 0, 0, 3, 3, 3);
        add(0, 0, 0, 0, 0, 3, 3, 3);
        add(0, 1, 3, 0, 1, 4, 3, 3);
        add(0, 1, 2, 0, 1, 4, 3, 3);

        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            drive(vt[i].clr, vt[i].iv, vt[i].d, vt[i].ordy);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vt[i].ov, vt[i].cnt, vt[i].mx, vt[i].mn);
        end

        // asynchronous reset while a result is pending, observed before the next edge
        drive(0, 1, 6, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("rst_release", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_all("post_rst_first", 0, 1, 6, 6);
        drive(0, 1, 2, 0);
        @(posedge clk);
        #1;
        check_all("post_rst_second", 0, 2, 6, 2);

        // randomized traffic against the window model
        model_reset();
        model_step(0, 1, 6, 0);
        model_step(0, 1, 2, 0);
        for (int i = 0; i < 600; i++) begin
            bit c, iv, ordy;
            int d;
            c    = ($urandom_range(0, 15) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) == 0);
            d    = $urandom_range(0, (1 << WIH) - 1);
            drive(c, iv, d, ordy);
            model_step(c, iv, d, ordy);
            @(posedge clk);
            #1;
            check_all($sformatf("rnd%0d", i), int'(m_hold), m_win.size(), m_max, m_min);
        end

        drive(0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
